// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding,
// frame geometry and the parity helper used by the receive datapath.
package serial_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Frame geometry: start + 8 data + parity + stop.
    localparam int DATA_BITS   = 8;
    localparam int FRAME_EDGES = 11;

    // True when the 8 data bits plus the received parity bit do not
    // have the parity selected by odd_sel (0 = even, 1 = odd).
    function automatic logic parity_mismatch(
        input logic [DATA_BITS-1:0] data,
        input logic                 par_bit,
        input logic                 odd_sel
    );
        return (^{data, par_bit}) != odd_sel;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Brings SCin and SDin into the Clk domain through identical flop chains
// and produces a one-cycle sc_rise pulse on each synchronised SCin rise.
// Keeping both chains the same depth preserves their relative alignment,
// so SDin is always sampled with the same skew as the clock it rides on.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sc_in,
    input  logic sd_in,
    output logic sc_rise,
    output logic sd_sync
);

    logic [SYNC_STAGES-1:0] sc_sync_q;
    logic [SYNC_STAGES-1:0] sc_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_d;
    logic                   sc_prev_q;
    logic                   sc_prev_d;

    // Next state of both synchroniser chains and the SCin history flop.
    always_comb begin
        sc_sync_d = {sc_sync_q[SYNC_STAGES-2:0], sc_in};
        sd_sync_d = {sd_sync_q[SYNC_STAGES-2:0], sd_in};
        sc_prev_d = sc_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser flops; all clear to 0 so a high SCin at release yields one rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_sync_q <= '0;
            sd_sync_q <= '0;
            sc_prev_q <= 1'b0;
        end else begin
            sc_sync_q <= sc_sync_d;
            sd_sync_q <= sd_sync_d;
            sc_prev_q <= sc_prev_d;
        end
    end

    assign sc_rise = sc_sync_q[SYNC_STAGES-1] & ~sc_prev_q;
    assign sd_sync = sd_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sreceiver_sync.sv
// Serial frame receiver: start bit, 8 data bits LSB first, parity, stop.
// SCin/SDin are asynchronous; they are synchronised in sync_edge_det and
// the FSM advances only in the Clk cycle carrying a synchronised SCin rise.
// Accepted frames update PDout/ParErr and pulse PDready; a low stop bit
// pulses FrmErr and leaves PDout/ParErr untouched.
module sreceiver_sync
    import serial_pkg::*;
#(
    parameter bit PARITY_ODD  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 SCin,
    input  logic                 SDin,
    output logic [DATA_BITS-1:0] PDout,
    output logic                 PDready,
    output logic                 ParErr,
    output logic                 FrmErr
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 sc_rise;
    logic                 sd_bit;

    rx_state_e            state_q;
    rx_state_e            state_d;
    logic [2:0]           cnt_q;
    logic [2:0]           cnt_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic                 mism_q;
    logic                 mism_d;
    logic [DATA_BITS-1:0] pdout_q;
    logic [DATA_BITS-1:0] pdout_d;
    logic                 parerr_q;
    logic                 parerr_d;
    logic                 pdready_q;
    logic                 pdready_d;
    logic                 frmerr_q;
    logic                 frmerr_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (Clk),
        .rst     (Reset),
        .sc_in   (SCin),
        .sd_in   (SDin),
        .sc_rise (sc_rise),
        .sd_sync (sd_bit)
    );

    // Frame FSM and datapath next-state; nothing moves without sc_rise,
    // and the two status pulses default low so they last one cycle only.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        mism_d    = mism_q;
        pdout_d   = pdout_q;
        parerr_d  = parerr_q;
        pdready_d = 1'b0;
        frmerr_d  = 1'b0;

        if (sc_rise) begin
            case (state_q)
                ST_IDLE: begin
                    // A high line is idle; a low bit is the start bit.
                    if (!sd_bit) begin
                        state_d = ST_DATA;
                        cnt_d   = 3'd0;
                    end
                end

                ST_DATA: begin
                    // LSB arrives first, so shifting right leaves bit 0 in place after 8 bits.
                    shreg_d = {sd_bit, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end

                ST_PARITY: begin
                    mism_d  = parity_mismatch(shreg_q, sd_bit, PARITY_ODD);
                    state_d = ST_STOP;
                end

                ST_STOP: begin
                    if (sd_bit) begin
                        pdout_d   = shreg_q;
                        parerr_d  = mism_q;
                        pdready_d = 1'b1;
                    end else begin
                        frmerr_d  = 1'b1;
                    end
                    // Returning to IDLE here lets a start bit follow immediately.
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // All receiver state and registered outputs; reset discards any partial frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            shreg_q   <= '0;
            mism_q    <= 1'b0;
            pdout_q   <= '0;
            parerr_q  <= 1'b0;
            pdready_q <= 1'b0;
            frmerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            mism_q    <= mism_d;
            pdout_q   <= pdout_d;
            parerr_q  <= parerr_d;
            pdready_q <= pdready_d;
            frmerr_q  <= frmerr_d;
        end
    end

    assign PDout   = pdout_q;
    assign PDready = pdready_q;
    assign ParErr  = parerr_q;
    assign FrmErr  = frmerr_q;

endmodule

// File: tb/tb_sreceiver_sync.sv
// Bench for sreceiver_sync: directed frames with literal expectations plus
// randomised frames. A frame-level model predicts, for every Clk cycle, the
// values of PDout/ParErr and whether PDready or FrmErr must be pulsing.
module tb_sreceiver_sync;

    localparam int S = 2;  // synchroniser depth under test

    logic       Clk = 1'b0;
    logic       Reset;
    logic       SCin;
    logic       SDin;
    logic [7:0] PDout;
    logic       PDready;
    logic       ParErr;
    logic       FrmErr;

    sreceiver_sync #(
        .PARITY_ODD  (1'b0),
        .SYNC_STAGES (S)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .SCin    (SCin),
        .SDin    (SDin),
        .PDout   (PDout),
        .PDready (PDready),
        .ParErr  (ParErr),
        .FrmErr  (FrmErr)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Scheduled outcomes keyed by the cycle in which the pulse must be visible.
    int         evt_kind[int];   // 1 = accepted frame, 2 = framing error
    logic [7:0] evt_data[int];
    logic       evt_perr[int];

    logic [7:0] m_pdout  = 8'h00;
    logic       m_parerr = 1'b0;
    int n_rdy = 0, n_frm = 0;
    int exp_rdy_tot = 0, exp_frm_tot = 0;
    bit done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the frame-level model.
    initial begin
        int kind;
        forever begin
            @(posedge Clk);
            #1;
            if (done) break;
            if (Reset === 1'b1) begin
                m_pdout  = 8'h00;
                m_parerr = 1'b0;
                kind     = 0;
            end else begin
                kind = evt_kind.exists(cyc) ? evt_kind[cyc] : 0;
                if (kind == 1) begin
                    m_pdout  = evt_data[cyc];
                    m_parerr = evt_perr[cyc];
                end
            end
            check("pdready", 32'(PDready), 32'(kind == 1));
            check("frmerr",  32'(FrmErr),  32'(kind == 2));
            check("pdout",   32'(PDout),   32'(m_pdout));
            check("parerr",  32'(ParErr),  32'(m_parerr));
            if (PDready === 1'b1) n_rdy++;
            if (FrmErr  === 1'b1) n_frm++;
        end
    end

    // One serial bit: data set while SCin is low, sampled on the SCin rise.
    // kind != 0 marks the stop bit and schedules the resulting output event.
    task automatic send_bit(input logic b, input int kind, input logic [7:0] d, input logic perr);
        SDin = b;
        SCin = 1'b0;
        repeat ($urandom_range(S + 4, S + 1)) @(negedge Clk);
        SCin = 1'b1;
        if (kind != 0) begin
            // Rise seen by S flops, edge-detected, then registered: S+1 edges.
            evt_kind[cyc + S + 1] = kind;
            evt_data[cyc + S + 1] = d;
            evt_perr[cyc + S + 1] = perr;
            if (kind == 1) exp_rdy_tot++;
            else           exp_frm_tot++;
        end
        repeat ($urandom_range(S + 4, S + 1)) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic perr;
        perr = (($countones(d) + int'(par)) % 2) != 0;  // even parity expected
        send_bit(1'b0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0, 8'h00, 1'b0);
        send_bit(par, 0, 8'h00, 1'b0);
        send_bit(stop, stop ? 1 : 2, d, perr);
    endtask

    // Stimulus: directed cases with literal expectations, then random frames.
    initial begin
        int r0, f0;
        Reset = 1'b1;
        SCin  = 1'b0;
        SDin  = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_pdout",   32'(PDout),   32'h00);
        check("rst_pdready", 32'(PDready), 32'h0);
        check("rst_parerr",  32'(ParErr),  32'h0);
        check("rst_frmerr",  32'(FrmErr),  32'h0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        // 0xA5 with correct even parity.
        r0 = n_rdy; f0 = n_frm;
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_pdout",  32'(PDout),  32'hA5);
        check("a5_parerr", 32'(ParErr), 32'h0);
        check("a5_rdy",    32'(n_rdy - r0), 32'd1);
        check("a5_frm",    32'(n_frm - f0), 32'd0);

        // 0xA5 with wrong parity, then 0x3C clears ParErr.
        send_frame(8'hA5, 1'b1, 1'b1);
        check("a5p_pdout",  32'(PDout),  32'hA5);
        check("a5p_parerr", 32'(ParErr), 32'h1);
        send_frame(8'h3C, 1'b0, 1'b1);
        check("3c_pdout",  32'(PDout),  32'h3C);
        check("3c_parerr", 32'(ParErr), 32'h0);

        // 0x81 with a low stop bit: framing error only.
        r0 = n_rdy; f0 = n_frm;
        send_frame(8'h81, 1'b0, 1'b0);
        check("81_pdout", 32'(PDout), 32'h3C);
        check("81_rdy",   32'(n_rdy - r0), 32'd0);
        check("81_frm",   32'(n_frm - f0), 32'd1);

        // Idle-line clocking: 20 SCin rises with SDin high.
        r0 = n_rdy; f0 = n_frm;
        for (int i = 0; i < 20; i++) send_bit(1'b1, 0, 8'h00, 1'b0);
        check("idle_rdy", 32'(n_rdy - r0), 32'd0);
        check("idle_frm", 32'(n_frm - f0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("5a_pdout", 32'(PDout), 32'h5A);

        // Reset after the start bit and 4 data bits of 0xF0; SCin left high.
        send_bit(1'b0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 0, 8'h00, 1'b0);
        SDin  = 1'b1;
        Reset = 1'b1;
        #1;
        check("mrst_pdout",   32'(PDout),   32'h00);
        check("mrst_pdready", 32'(PDready), 32'h0);
        check("mrst_parerr",  32'(ParErr),  32'h0);
        check("mrst_frmerr",  32'(FrmErr),  32'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (S + 3) @(negedge Clk);
        send_frame(8'h3C, 1'b0, 1'b1);
        check("post_rst_pdout",  32'(PDout),  32'h3C);
        check("post_rst_parerr", 32'(ParErr), 32'h0);

        // Back-to-back 0x00 then 0xFF with no idle bits.
        r0 = n_rdy;
        send_frame(8'h00, 1'b0, 1'b1);
        check("b2b0_pdout",  32'(PDout),  32'h00);
        check("b2b0_parerr", 32'(ParErr), 32'h0);
        send_frame(8'hFF, 1'b0, 1'b1);
        check("b2b1_pdout",  32'(PDout),  32'hFF);
        check("b2b1_parerr", 32'(ParErr), 32'h0);
        check("b2b_rdy",     32'(n_rdy - r0), 32'd2);

        // Random frames: random data, parity, stop bit and idle gap.
        for (int f = 0; f < 60; f++) begin
            logic [7:0] d;
            logic       par;
            logic       stop;
            d    = 8'($urandom);
            par  = ^d;
            if ($urandom_range(3, 0) == 0) par = ~par;
            stop = ($urandom_range(7, 0) != 0);
            for (int g = $urandom_range(3, 0); g > 0; g--) send_bit(1'b1, 0, 8'h00, 1'b0);
            send_frame(d, par, stop);
        end

        repeat (S + 6) @(negedge Clk);
        check("total_rdy", 32'(n_rdy), 32'(exp_rdy_tot));
        check("total_frm", 32'(n_frm), 32'(exp_frm_tot));
        done = 1'b1;
        repeat (2) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sreceiver_sync.md
SRECEIVER_SYNC -- requirements
Module: sreceiver_sync

Interface
REQ-001 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity over 8 data bits plus parity bit.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: synchroniser depth applied to SCin and SDin.
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 SCin  input  1  serial clock from the transmitter; asynchronous to Clk.
REQ-006 SDin  input  1  serial data from the transmitter; idles high.
REQ-007 PDout  output  8  last correctly framed data byte.
REQ-008 PDready  output  1  one-Clk pulse, frame accepted.
REQ-009 ParErr  output  1  parity status of the last accepted frame; level, held until the next accepted frame.
REQ-010 FrmErr  output  1  one-Clk pulse, stop bit sampled low.

Function
REQ-011 Frame format: start bit 0, 8 data bits LSB first, 1 parity bit, stop bit 1; 11 SCin rising edges per frame.
REQ-012 SCin and SDin shall pass through identical SYNC_STAGES-deep flop chains; one extra flop on SCin gives sc_rise = sync_last & ~prev.
REQ-013 All bit sampling uses synchronised SDin in the Clk cycle where sc_rise = 1; no other cycle changes FSM state.
REQ-014 States: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on sc_rise with SDin = 0 -> DATA, bit counter = 0; with SDin = 1 -> stay IDLE.
REQ-016 DATA: on sc_rise, shift SDin into bit 7 of the shift register with a right shift; increment the 3-bit counter; after the 8th bit (counter = 7) -> PARITY.
REQ-017 PARITY: on sc_rise, capture the parity bit; mismatch = ^{shreg, bit} != PARITY_ODD -> STOP.
REQ-018 STOP, sc_rise, SDin = 1: PDout <= shreg, ParErr <= mismatch, PDready = 1 for the next Clk cycle only -> IDLE.
REQ-019 STOP, sc_rise, SDin = 0: FrmErr = 1 for the next Clk cycle only; PDout and ParErr unchanged; PDready stays 0 -> IDLE.
REQ-020 PDready and FrmErr shall be registered; latency is exactly 1 Clk after the sc_rise cycle of the stop bit.
REQ-021 PDready and FrmErr shall never be high in the same cycle.
REQ-022 Back-to-back frames: a start bit on the first sc_rise after STOP shall be accepted without idle bits.
REQ-023 Timing requirement on the source: SCin high and low phases of at least SYNC_STAGES+1 Clk periods each. Narrower pulses are unsupported; no detection is required.

Reset
REQ-024 Reset asserted at any time, including mid-frame: state = IDLE, counter = 0, shreg = 0x00, PDout = 0x00, PDready = 0, ParErr = 0, FrmErr = 0, sync flops = 0.
REQ-025 After Reset deasserts, a partial frame in progress shall be discarded; reception resumes at the next start bit.
REQ-026 Sync flops reset to 0. A high SCin at reset release therefore produces one sc_rise, which IDLE ignores when SDin = 1.

Structure
REQ-027 Package serial_pkg: FSM state typedef, DATA_BITS = 8, FRAME_EDGES = 11.
REQ-028 Sub-module sync_edge_det (SYNC_STAGES parameter) for the SCin and SDin synchronisers and the sc_rise pulse; the FSM and datapath live in sreceiver_sync.

Verification
REQ-029 Frame 0xA5, parity bit 0 (even), stop 1 -> PDout = 0xA5, PDready single pulse 1 Clk after the stop-bit sc_rise, ParErr = 0, FrmErr = 0.
REQ-030 Frame 0xA5, parity bit 1 -> PDout = 0xA5, PDready pulse, ParErr = 1; then frame 0x3C with parity 0 -> ParErr returns to 0.
REQ-031 Frame 0x81 with stop bit 0 -> FrmErr single pulse, no PDready, PDout keeps its previous value.
REQ-032 Reset pulse after 4 data bits of 0xF0 -> all outputs 0 immediately; next full frame 0x3C -> PDout = 0x3C, ParErr = 0.
REQ-033 SCin toggling 20 edges with SDin = 1 -> no PDready, no FrmErr, state stays IDLE.
REQ-034 Back-to-back frames 0x00 then 0xFF, both with parity 0, no idle gap -> two PDready pulses, PDout = 0x00 then 0xFF, ParErr = 0 both.
